// File: rtl/out_display.sv
// out_display
//   Output display stage behind the processor. Every change of the 8-bit
//   result bus is converted to decimal with a sequential shift-add-3
//   (double-dabble) engine, one bit per cycle. The result is shown on a
//   time-multiplexed 4-digit seven-segment display with leading-zero
//   blanking. A registered copy of the processor halt flag is also provided.
//
//   Build option: define OUT_DISPLAY_SIGNED_EN to treat out_val as two's
//   complement. The sign digit then shows a minus for negative values.
//   Without it, out_val is unsigned 0..255 and the sign digit stays blank.
//
// Parameters
//   SCAN_DIV  clock cycles each digit stays enabled (>= 2)
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   out_val   processor result bus, sampled every cycle while idle
//   halt      processor halt flag
//   seg       segments {a,b,c,d,e,f,g} of the enabled digit, active-high
//   an        one-hot digit enable (bit 0 = ones, bit 3 = sign)
//   busy      high while a conversion is in flight
//   halt_led  halt delayed by one cycle
module out_display #(
  parameter int SCAN_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] out_val,
  input  logic       halt,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy,
  output logic       halt_led
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b0000001;

  state_t      state;
  logic [7:0]  cap;
  logic [19:0] shreg;   // {hundreds, tens, ones, binary}
  logic [3:0]  iter;
  logic [3:0]  disp_h;
  logic [3:0]  disp_t;
  logic [3:0]  disp_o;
  logic        disp_neg;
  logic [PW-1:0] pcnt;
  logic [1:0]  dix;

  logic [7:0]  mag;
  logic [19:0] adj;

  // Magnitude loaded into the binary field on capture.
`ifdef OUT_DISPLAY_SIGNED_EN
  // -128 negates to 8'h80, which read unsigned is the wanted 128.
  assign mag = out_val[7] ? (~out_val + 8'd1) : out_val;
`else
  assign mag = out_val;
  assign disp_neg = 1'b0;
`endif

  // Add-3 correction applied to each BCD nibble before the shift.
  // NOTE: combinational logic uses blocking '=' with a default assignment
  // first so no latch can be inferred; clocked state uses '<=' only.
  always_comb begin
    adj = shreg;
    for (int n = 0; n < 3; n++) begin
      if (shreg[8 + 4*n +: 4] >= 4'd5)
        adj[8 + 4*n +: 4] = shreg[8 + 4*n +: 4] + 4'd3;
    end
  end

  // Conversion FSM and display registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cap    <= 8'd0;
      shreg  <= 20'd0;
      iter   <= 4'd0;
      disp_h <= 4'd0;
      disp_t <= 4'd0;
      disp_o <= 4'd0;
`ifdef OUT_DISPLAY_SIGNED_EN
      disp_neg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Only compared while idle, so values that come and go during a
          // conversion are dropped and the latest one wins.
          if (out_val != cap) begin
            cap   <= out_val;
            shreg <= {12'd0, mag};
            iter  <= 4'd0;
            state <= CONV;
          end
        end
        CONV: begin
          shreg <= {adj[18:0], 1'b0};
          iter  <= iter + 4'd1;
          if (iter == 4'd7)
            state <= DONE;
        end
        DONE: begin
          // Display registers change only here, so partial BCD never shows.
          disp_h <= shreg[19:16];
          disp_t <= shreg[15:12];
          disp_o <= shreg[11:8];
`ifdef OUT_DISPLAY_SIGNED_EN
          disp_neg <= cap[7];
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit scan, free-running and independent of the conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      dix  <= 2'd0;
    end else if (pcnt == PW'(SCAN_DIV - 1)) begin
      pcnt <= '0;
      dix  <= dix + 2'd1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      halt_led <= 1'b0;
    else
      halt_led <= halt;
  end

  function automatic logic [6:0] digit7(input logic [3:0] d);
    case (d)
      4'd0:    digit7 = 7'b1111110;
      4'd1:    digit7 = 7'b0110000;
      4'd2:    digit7 = 7'b1101101;
      4'd3:    digit7 = 7'b1111001;
      4'd4:    digit7 = 7'b0110011;
      4'd5:    digit7 = 7'b1011011;
      4'd6:    digit7 = 7'b1011111;
      4'd7:    digit7 = 7'b1110000;
      4'd8:    digit7 = 7'b1111111;
      4'd9:    digit7 = 7'b1111011;
      default: digit7 = SEG_BLANK;
    endcase
  endfunction

  // Outputs decode straight from registers, so they carry no input paths.
  always_comb begin
    seg = SEG_BLANK;
    case (dix)
      2'd0: seg = digit7(disp_o);
      2'd1: seg = (disp_h == 4'd0 && disp_t == 4'd0) ? SEG_BLANK : digit7(disp_t);
      2'd2: seg = (disp_h == 4'd0) ? SEG_BLANK : digit7(disp_h);
      2'd3: seg = disp_neg ? SEG_MINUS : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
  end

  assign an   = 4'b0001 << dix;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_out_display.sv
// tb_out_display
//   Self-checking bench for out_display. A cycle-level reference model kept
//   as plain numbers (captured value, remaining conversion cycles, displayed
//   value, cycles since reset) predicts busy, an, seg and halt_led after
//   every rising edge. Directed sequences are followed by random traffic.
module tb_out_display;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] out_val;
  logic       halt;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;
  logic       halt_led;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int         m_cap;
  int         m_cnt;
  int         m_disp;
  int         m_cyc;
  logic       m_halt;
  logic [6:0] segtab [10];

  out_display #(.SCAN_DIV(SD)) dut (
    .clk      (clk),
    .reset    (reset),
    .out_val  (out_val),
    .halt     (halt),
    .seg      (seg),
    .an       (an),
    .busy     (busy),
    .halt_led (halt_led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Expected segments for the enabled digit of the currently shown value.
  function automatic logic [6:0] exp_seg(input int val, input int d);
    int mag;
    bit neg;
    int h, t, o;
`ifdef OUT_DISPLAY_SIGNED_EN
    mag = (val >= 128) ? 256 - val : val;
    neg = (val >= 128);
`else
    mag = val;
    neg = 1'b0;
`endif
    h = mag / 100;
    t = (mag / 10) % 10;
    o = mag % 10;
    case (d)
      0:       exp_seg = segtab[o];
      1:       exp_seg = (h == 0 && t == 0) ? 7'b0000000 : segtab[t];
      2:       exp_seg = (h == 0) ? 7'b0000000 : segtab[h];
      default: exp_seg = neg ? 7'b0000001 : 7'b0000000;
    endcase
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then
  // compare all outputs 1 time unit later.
  task automatic step();
    int d;
    @(posedge clk);
    if (reset) begin
      m_cap  = 0;
      m_cnt  = 0;
      m_disp = 0;
      m_cyc  = 0;
      m_halt = 1'b0;
    end else begin
      m_halt = halt;
      m_cyc++;
      if (m_cnt == 0) begin
        if (int'(out_val) != m_cap) begin
          m_cap = int'(out_val);
          m_cnt = 9;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) m_disp = m_cap;
      end
    end
    #1;
    d = (m_cyc / SD) % 4;
    check("busy", 32'(busy), 32'(m_cnt != 0));
    check("an", 32'(an), 32'(1 << d));
    check("seg", 32'(seg), 32'(exp_seg(m_disp, d)));
    check("halt_led", 32'(halt_led), 32'(m_halt));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    segtab[0] = 7'b1111110; segtab[1] = 7'b0110000; segtab[2] = 7'b1101101;
    segtab[3] = 7'b1111001; segtab[4] = 7'b0110011; segtab[5] = 7'b1011011;
    segtab[6] = 7'b1011111; segtab[7] = 7'b1110000; segtab[8] = 7'b1111111;
    segtab[9] = 7'b1111011;
    m_cap = 0; m_cnt = 0; m_disp = 0; m_cyc = 0; m_halt = 1'b0;

    // Reset for 3 cycles, then a couple of full scan frames showing "0".
    reset = 1'b1; out_val = 8'd0; halt = 1'b0;
    run(3);
    check("reset_an", 32'(an), 32'h1);
    check("reset_seg", 32'(seg), 32'h7E);
    check("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    run(4 * SD * 2);

    // 197 (or -59 signed): 9-cycle conversion, then hold two frames.
    out_val = 8'd197;
    run(1);
    check("busy_after_capture", 32'(busy), 32'h1);
    run(8);
    check("busy_before_done", 32'(busy), 32'h1);
    run(1);
    check("busy_after_done", 32'(busy), 32'h0);
    run(4 * SD * 2);

    // 5 -> 42 -> 99 with 42 arriving and leaving during the conversion of 5.
    out_val = 8'd5;  run(3);
    out_val = 8'd42; run(3);
    out_val = 8'd99; run(30);
    run(4 * SD);

    // Sign-relevant values: F6 and 80.
    out_val = 8'hF6; run(12 + 4 * SD);
    out_val = 8'h80; run(12 + 4 * SD);

    // Reset in the middle of converting 255 while 0 is shown.
    out_val = 8'd0; reset = 1'b1; run(2); reset = 1'b0; run(2);
    out_val = 8'd255; run(5);
    reset = 1'b1; run(1);
    check("midreset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    run(9);
    check("restart_busy_last", 32'(busy), 32'h1);
    run(1 + 4 * SD);

    // Halt pulse during a conversion.
    out_val = 8'd17; run(2);
    halt = 1'b1; run(1);
    halt = 1'b0; run(2);
    run(12 + 4 * SD);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) out_val = 8'($urandom_range(0, 255));
      halt  = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
